// File: rtl/div_mon_pkg.sv
// Shared types and helpers for the divided-clock monitor.
package div_mon_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        MEAS   = 2'd1,
        LOCKED = 2'd2
    } mon_state_t;

    // A 50%-duty divider by an odd ratio can only hold high for floor or
    // ceil of half the period; an even ratio must be exactly half.
    function automatic logic duty_ok(input int high, input int n);
        if (n % 2 == 1) begin
            return (high == (n - 1) / 2) || (high == (n + 1) / 2);
        end else begin
            return high == n / 2;
        end
    endfunction

endpackage

// File: rtl/sync_rise_det.sv
// Two-flop synchroniser with an extra delay stage that yields a one-cycle
// pulse on each rising edge of an asynchronous input.
module sync_rise_det (
    input  logic clk_in,
    input  logic rst_n,
    input  logic async_in,
    output logic sync_o,
    output logic rise_o
);

    logic s1_q, s2_q, s3_q;
    logic s1_d, s2_d, s3_d;

    // Next-state of the shift chain: s1/s2 resolve metastability, s3 is the
    // one-cycle-old copy used for edge detection.
    always_comb begin
        s1_d = async_in;
        s2_d = s1_q;
        s3_d = s2_q;
    end

    // Synchroniser and delay registers.
    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            s1_q <= 1'b0;
            s2_q <= 1'b0;
            s3_q <= 1'b0;
        end else begin
            s1_q <= s1_d;
            s2_q <= s2_d;
            s3_q <= s3_d;
        end
    end

    assign sync_o = s2_q;
    assign rise_o = s2_q & ~s3_q;

endmodule

// File: rtl/div_clk_monitor.sv
// Period/duty/stall monitor for a divided clock sampled in its source domain.
// Measures each divided-clock period and high time, locks after a run of
// good measurements and raises sticky error flags for the CSR.
module div_clk_monitor
    import div_mon_pkg::*;
#(
    parameter int N        = 7,
    parameter int LOCK_CNT = 4,
    parameter int CNT_W    = 8
) (
    input  logic             clk_in,
    input  logic             rst_n,
    input  logic             div_clk,
    input  logic             clr_err,
    output logic             meas_valid,
    output logic [CNT_W-1:0] period_o,
    output logic [CNT_W-1:0] high_o,
    output logic             locked,
    output logic             err_period,
    output logic             err_duty,
    output logic             err_stall
);

    localparam logic [CNT_W-1:0] CNT_MAX   = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] STALL_LIM = CNT_W'(2 * N);
    localparam logic [CNT_W-1:0] N_VAL     = CNT_W'(N);
    localparam int               GOOD_W    = $clog2(LOCK_CNT + 1);
    localparam logic [GOOD_W-1:0] GOOD_LAST = GOOD_W'(LOCK_CNT - 1);

    logic div_sync;
    logic rise;

    sync_rise_det u_sync (
        .clk_in   (clk_in),
        .rst_n    (rst_n),
        .async_in (div_clk),
        .sync_o   (div_sync),
        .rise_o   (rise)
    );

    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [CNT_W-1:0]  hcnt_q, hcnt_d;
    logic [CNT_W-1:0]  period_q, period_d;
    logic [CNT_W-1:0]  high_q, high_d;
    logic              meas_valid_q, meas_valid_d;
    mon_state_t        state_q, state_d;
    logic [GOOD_W-1:0] good_cnt_q, good_cnt_d;
    logic              locked_q, locked_d;
    logic              err_period_q, err_period_d;
    logic              err_duty_q, err_duty_d;
    logic              err_stall_q, err_stall_d;

    logic period_bad, duty_bad, meas_good, stall;
    logic set_period, set_duty, set_stall;

    // Period and high-time counters restart on each rise and saturate so a
    // dead clock can never wrap back into a plausible value.
    always_comb begin
        cnt_d  = cnt_q;
        hcnt_d = hcnt_q;
        if (rise) begin
            cnt_d  = CNT_W'(1);
            hcnt_d = CNT_W'(1);
        end else begin
            if (cnt_q != CNT_MAX) begin
                cnt_d = cnt_q + 1'b1;
            end
            if (div_sync && (hcnt_q != CNT_MAX)) begin
                hcnt_d = hcnt_q + 1'b1;
            end
        end
    end

    // Capture a measurement on each rise; the rise that leaves IDLE only
    // restarts the counters and is not reported.
    always_comb begin
        period_d     = period_q;
        high_d       = high_q;
        meas_valid_d = rise && (state_q != IDLE);
        if (rise) begin
            period_d = cnt_q;
            high_d   = hcnt_q;
        end
    end

    // Judge the registered measurement and run the lock FSM; a stall
    // overrides everything and drops back to IDLE.
    always_comb begin
        period_bad = (period_q != N_VAL);
        duty_bad   = !duty_ok(int'(high_q), N);
        meas_good  = !period_bad && !duty_bad;
        stall      = (state_q != IDLE) && (cnt_q == STALL_LIM) && !rise;

        state_d    = state_q;
        good_cnt_d = good_cnt_q;
        set_period = 1'b0;
        set_duty   = 1'b0;
        set_stall  = 1'b0;

        case (state_q)
            IDLE: begin
                if (rise) begin
                    state_d    = MEAS;
                    good_cnt_d = '0;
                end
            end
            MEAS: begin
                if (meas_valid_q) begin
                    if (meas_good) begin
                        good_cnt_d = good_cnt_q + 1'b1;
                        if (good_cnt_q == GOOD_LAST) begin
                            state_d = LOCKED;
                        end
                    end else begin
                        set_period = period_bad;
                        set_duty   = duty_bad;
                        good_cnt_d = '0;
                    end
                end
            end
            LOCKED: begin
                if (meas_valid_q && !meas_good) begin
                    set_period = period_bad;
                    set_duty   = duty_bad;
                    good_cnt_d = '0;
                    state_d    = MEAS;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if (stall) begin
            set_stall = 1'b1;
            state_d   = IDLE;
        end
    end

    // Sticky error flags; a new error in the same cycle as clr_err wins.
    always_comb begin
        err_period_d = (err_period_q & ~clr_err) | set_period;
        err_duty_d   = (err_duty_q   & ~clr_err) | set_duty;
        err_stall_d  = (err_stall_q  & ~clr_err) | set_stall;
        locked_d     = (state_d == LOCKED);
    end

    // State registers for counters, measurement, FSM and status.
    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q        <= '0;
            hcnt_q       <= '0;
            period_q     <= '0;
            high_q       <= '0;
            meas_valid_q <= 1'b0;
            state_q      <= IDLE;
            good_cnt_q   <= '0;
            locked_q     <= 1'b0;
            err_period_q <= 1'b0;
            err_duty_q   <= 1'b0;
            err_stall_q  <= 1'b0;
        end else begin
            cnt_q        <= cnt_d;
            hcnt_q       <= hcnt_d;
            period_q     <= period_d;
            high_q       <= high_d;
            meas_valid_q <= meas_valid_d;
            state_q      <= state_d;
            good_cnt_q   <= good_cnt_d;
            locked_q     <= locked_d;
            err_period_q <= err_period_d;
            err_duty_q   <= err_duty_d;
            err_stall_q  <= err_stall_d;
        end
    end

    assign meas_valid = meas_valid_q;
    assign period_o   = period_q;
    assign high_o     = high_q;
    assign locked     = locked_q;
    assign err_period = err_period_q;
    assign err_duty   = err_duty_q;
    assign err_stall  = err_stall_q;

endmodule
